// File: rtl/stmt_sched.sv
// Two-requester scheduler for a shared int-declaration checker.
// One requester at a time owns the checker. It streams characters until ';',
// a stall timeout or the length limit. The owner then gets a one-cycle result.
module stmt_sched #(
  parameter int TIMEOUT = 16,
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic [1:0]  grant,
  output logic        chk_en,
  output logic [7:0]  chk_char,
  output logic        chk_clr,
  input  logic        chk_out,
  output logic [1:0]  res_valid,
  output logic        res_ok,
  output logic        res_abort,
  output logic        busy
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT);
  localparam logic [LW-1:0] LEN_LIM   = LW'(MAX_LEN);
  localparam logic [7:0]    SEMI      = 8'h3B;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, ABORT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [LW-1:0] len_q, len_d;

  logic [7:0]    lane_sel [2];
  logic [7:0]    lane_char;
  logic [1:0]    pick;
  logic          xfer;
  logic          abort_clr;

  // The grant is one-hot, so OR-ing the masked lanes selects the owner's character.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_sel[gi] = grant_q[gi] ? req_data[8*gi +: 8] : 8'h00;
  end
  assign lane_char = lane_sel[0] | lane_sel[1];

  // A character moves only while streaming and only on the owner's lane.
  assign xfer = (state_q == STREAM) && (|(req_valid & grant_q));

  // Round-robin choice: the pointer breaks ties, and a lone requester always wins.
  always_comb begin
    pick = req_valid;
    if (req_valid == 2'b11) begin
      pick = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Next-state logic and the outputs of the FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    len_d     = len_q;
    req_ready = 2'b00;
    res_valid = 2'b00;
    res_ok    = 1'b0;
    res_abort = 1'b0;
    abort_clr = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        len_d   = '0;
        if (|req_valid) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        req_ready = grant_q;
        if (xfer) begin
          stall_d = '0;
          len_d   = (len_q == LEN_LIM) ? len_q : len_q + LW'(1);
          if (lane_char == SEMI) begin
            len_d   = '0;
            state_d = WAIT_RES;
          end else if (len_q == LEN_LIM - LW'(1)) begin
            // The MAX_LEN-th character was forwarded without ending the statement.
            state_d = ABORT;
          end
        end else begin
          stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + SW'(1);
          if (stall_q == STALL_LIM - SW'(1)) begin
            state_d = ABORT;
          end
        end
      end
      WAIT_RES: begin
        res_valid = grant_q;
        res_ok    = chk_out;
        grant_d   = 2'b00;
        ptr_d     = ~grant_q[1];
        stall_d   = '0;
        len_d     = '0;
        state_d   = IDLE;
      end
      ABORT: begin
        abort_clr = 1'b1;
        res_valid = grant_q;
        res_abort = 1'b1;
        grant_d   = 2'b00;
        ptr_d     = ~grant_q[1];
        stall_d   = '0;
        len_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State register. An asynchronous reset drops any statement in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      stall_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      len_q   <= len_d;
    end
  end

  assign grant    = grant_q;
  assign chk_en   = xfer;
  assign chk_char = lane_char;
  // The checker also restarts while this block is held in reset.
  assign chk_clr  = abort_clr | ~reset;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/stmt_sched.md
STMT_SCHED -- requirements
Module: stmt_sched

Interface
REQ-001 Parameter: TIMEOUT, default 16, stall cycles in STREAM before abort.
REQ-002 Parameter: MAX_LEN, default 64, maximum characters accepted per statement, ';' included.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting low clears all state immediately.
REQ-005 req_valid  input  2  per-requester character-valid; bit i belongs to requester i.
REQ-006 req_data  input  16  per-requester ASCII character; requester i uses bits [8i+7:8i].
REQ-007 req_ready  output  2  per-requester accept strobe; a character transfers when req_valid[i] & req_ready[i].
REQ-008 grant  output  2  one-hot registered owner of the shared checker; 2'b00 when idle.
REQ-009 chk_en  output  1  clock-enable to the shared int-declaration checker; high only on a transfer cycle.
REQ-010 chk_char  output  8  character presented to the checker; equals the granted lane of req_data, 8'h00 when not granted.
REQ-011 chk_clr  output  1  active-high synchronous clear to the checker.
REQ-012 chk_out  input  1  checker verdict: valid-statement flag, registered inside the checker.
REQ-013 res_valid  output  2  one-cycle result pulse to the requester owning the statement.
REQ-014 res_ok  output  1  statement verdict; qualified by res_valid.
REQ-015 res_abort  output  1  statement was aborted (timeout or length); qualified by res_valid.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement states IDLE, STREAM, WAIT_RES and ABORT, and only these.
REQ-018 IDLE: if any req_valid bit is high, the block SHALL register grant via round-robin and go to STREAM; no character is accepted in IDLE.
REQ-019 Round-robin: a 1-bit pointer names the preferred requester; both valid means pointer wins; one valid means that one wins; after every result the pointer SHALL point to the requester not just served.
REQ-020 STREAM: req_ready SHALL equal grant combinationally; the non-granted requester sees ready low.
REQ-021 Transfer cycle: chk_en=1 and chk_char=granted lane, same cycle, no registering.
REQ-022 Transfer of ';' (8'h3B) SHALL move to WAIT_RES; the length and stall counters clear.
REQ-023 WAIT_RES (exactly one cycle): the block SHALL assert res_valid[g]=1, res_ok=chk_out, res_abort=0, then clear grant, rotate the pointer and return to IDLE.
REQ-024 Stall counter: increments every STREAM cycle without a transfer and clears on a transfer; on reaching TIMEOUT the block SHALL go to ABORT.
REQ-025 Length counter: counts transfers; when the MAX_LEN-th transfer is not ';', the character is forwarded and the block SHALL go to ABORT next cycle.
REQ-026 ABORT (exactly one cycle): chk_clr=1, res_valid[g]=1, res_ok=0, res_abort=1, then clear grant, rotate the pointer and return to IDLE.
REQ-027 Dropping req_valid in STREAM SHALL NOT release the grant; only ';', timeout or length abort end ownership.
REQ-028 res_valid, res_ok and res_abort SHALL be 0 outside WAIT_RES/ABORT; at most one res_valid bit is high per cycle.
REQ-029 chk_clr SHALL also be high while reset is low, so the checker restarts with this block.
REQ-030 Counters SHALL saturate and never wrap: stall is ceil(log2(TIMEOUT+1)) bits, length is ceil(log2(MAX_LEN+1)) bits.

Reset
REQ-031 While reset=0: state=IDLE, grant=0, pointer=0, counters=0, req_ready=0, chk_en=0, chk_char=0, res_*=0, busy=0, chk_clr=1.
REQ-032 Reset asserted mid-statement SHALL discard the statement with no result pulse; the first grant after release favours requester 0.

Verification
REQ-033 Req0 sends "int a;" one char per cycle, chk_out=1 after ';' -> grant=01, 6 chk_en pulses, then res_valid=01, res_ok=1, res_abort=0, then busy=0.
REQ-034 Both requesters valid from reset release -> req0 served first, then req1; the next simultaneous request after both are served goes to req0 again.
REQ-035 Req1 granted, sends "int" then holds valid low for 16 cycles -> on the 16th stall cycle go to ABORT; res_valid=10, res_abort=1, res_ok=0, chk_clr=1 for one cycle.
REQ-036 MAX_LEN=8, req0 streams 8 characters with no ';' -> all 8 forwarded, then an ABORT pulse with res_abort=1; req1 is granted next if it is valid.
REQ-037 Reset pulled low during req0's STREAM -> all outputs go to 0 at once and chk_clr=1; after release there is no res_valid for the lost statement.
